cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of functional-unit requesters (index 0 alu, 1 mul, 2 br, 3 mem).
REQ-002 Parameter FIFO_DEPTH, default 2, per-requester result buffer entries (power of two, >=2).
REQ-003 Parameter STARVE_LIMIT, default 8, wait cycles after which a requester forces the grant.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset; asserted (0) clears all state immediately.
REQ-006 flush  input  1  synchronous pipeline flush (mispredict).
REQ-007 req_valid  input  NUM_REQ  result offered by requester i.
REQ-008 req_ready  output  NUM_REQ  requester i's buffer can accept this cycle.
REQ-009 req_rob_idx  input  NUM_REQ x 5  ROB index of offered result.
REQ-010 req_rd_addr  input  NUM_REQ x 5  architectural destination.
REQ-011 req_data  input  NUM_REQ x 32  result value.
REQ-012 cdb_valid  output  1  broadcast valid.
REQ-013 cdb_rob_idx, cdb_rd_addr, cdb_data  output  5/5/32  broadcast payload.
REQ-014 cdb_src  output  2  index of requester that owns the current broadcast.

Function
REQ-015 Push: requester i's entry enqueues at the edge where req_valid[i] && req_ready[i]; no other condition.
REQ-016 req_ready[i] = (count_i < FIFO_DEPTH), from registered count only; a full buffer reports not-ready even when a pop occurs that cycle (no bypass).
REQ-017 One broadcast slot per cycle; arbitration is combinational over non-empty buffer heads, and the winner pops at the same edge that loads the cdb_* output registers.
REQ-018 Latency: result accepted at edge k appears on cdb_* in the cycle after edge k+1 (minimum two edges, registered output).
REQ-019 Default policy round-robin: search starts at rr_ptr; after a grant to i, rr_ptr <= (i+1) mod NUM_REQ; no grant leaves rr_ptr unchanged.
REQ-020 Starvation: wait_i increments each cycle requester i is non-empty and not granted, saturates at STARVE_LIMIT, clears on grant or when empty.
REQ-021 If any wait_i == STARVE_LIMIT, the lowest such index wins, overriding round-robin; rr_ptr then updates per REQ-019.
REQ-022 No non-empty buffer: cdb_valid <= 0, cdb payload registers hold previous values.
REQ-023 Simultaneous push and pop on the same buffer: count unchanged, FIFO order preserved; pop of entry pushed in that same cycle is impossible (empty head not eligible).
REQ-024 Pointer wrap: buffer read/write pointers wrap modulo FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1.
REQ-025 Flush: at the edge with flush=1, all buffers empty, all wait_i = 0, rr_ptr = 0, cdb_valid <= 0; pushes in that cycle are discarded (flush wins).
REQ-026 cdb_src is valid only while cdb_valid = 1.

Reset
REQ-027 While rst = 0: cdb_valid = 0, cdb_rob_idx = 0, cdb_rd_addr = 0, cdb_data = 0, cdb_src = 0, all counts/pointers/wait_i = 0, rr_ptr = 0, req_ready = all ones.
REQ-028 Reset asserted mid-operation discards all buffered results without broadcast; first push after release follows REQ-018.

Verification
REQ-029 Single push: alu pushes rob 3, rd 5, data 0xDEADBEEF at edge 1 -> cdb_valid=1, src=0, payload match in cycle after edge 2, then cdb_valid=0.
REQ-030 Contention: all four push at edge 1, rr_ptr=0 -> broadcasts in order src 0,1,2,3 on four consecutive cycles.
REQ-031 Back-pressure: mul pushes twice with no grant possible (alu held busy) -> req_ready[1]=0 after second push; third offer not accepted until a pop completes.
REQ-032 Starvation: STARVE_LIMIT=2, requester 0 and 1 refill every cycle, requester 3 pending -> requester 3 granted no later than 3 cycles after becoming non-empty.
REQ-033 Flush: buffers holding 3 entries plus same-cycle push with flush=1 -> next cycle cdb_valid=0, req_ready all ones, no stale broadcast ever appears.
REQ-034 Async reset: drop rst between edges with buffered data -> outputs clear immediately without a clock edge; nothing broadcasts after release.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-unit result FIFOs feeding one registered
// broadcast slot, round-robin arbitration with a starvation override.
module cdb_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0][4:0]   req_rob_idx,
  input  logic [NUM_REQ-1:0][4:0]   req_rd_addr,
  input  logic [NUM_REQ-1:0][31:0]  req_data,
  output logic                      cdb_valid,
  output logic [4:0]                cdb_rob_idx,
  output logic [4:0]                cdb_rd_addr,
  output logic [31:0]               cdb_data,
  output logic [1:0]                cdb_src
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic [4:0]  rob;
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t        mem      [NUM_REQ][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr   [NUM_REQ];
  logic [PW-1:0] rd_ptr   [NUM_REQ];
  logic [CW-1:0] count    [NUM_REQ];
  logic [WW-1:0] wait_cnt [NUM_REQ];
  logic [IW-1:0] rr_ptr;

  logic [NUM_REQ-1:0] nonempty;
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic               grant_any;
  logic               starve_any;
  logic [IW-1:0]      grant_idx;
  logic [IW:0]        cand;
  entry_t             head;

  // Readiness comes from the registered count only; a same-cycle pop never frees a slot early.
  always_comb begin
    nonempty  = '0;
    req_ready = '0;
    push      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      nonempty[k]  = (count[k] != '0);
      req_ready[k] = (count[k] < CW'(FIFO_DEPTH));
      push[k]      = req_valid[k] && (count[k] < CW'(FIFO_DEPTH));
    end
  end

  always_comb begin
    starve_any = 1'b0;
    grant_any  = 1'b0;
    grant_idx  = '0;
    cand       = '0;
    // Lowest saturated waiter pre-empts the round-robin search.
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!starve_any && nonempty[k] && (wait_cnt[k] == WW'(STARVE_LIMIT))) begin
        starve_any = 1'b1;
        grant_any  = 1'b1;
        grant_idx  = IW'(k);
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!grant_any) begin
        cand = {1'b0, rr_ptr} + (IW+1)'(k);
        if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
        if (nonempty[cand[IW-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = cand[IW-1:0];
        end
      end
    end
    pop = '0;
    if (grant_any) pop[grant_idx] = 1'b1;
    head = mem[grant_idx][rd_ptr[grant_idx]];
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (push[k] && !flush) mem[k][wr_ptr[k]] <= {req_rob_idx[k], req_rd_addr[k], req_data[k]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        wr_ptr[k]   <= '0;
        rd_ptr[k]   <= '0;
        count[k]    <= '0;
        wait_cnt[k] <= '0;
      end
      rr_ptr      <= '0;
      cdb_valid   <= 1'b0;
      cdb_rob_idx <= '0;
      cdb_rd_addr <= '0;
      cdb_data    <= '0;
      cdb_src     <= '0;
    end else if (flush) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        wr_ptr[k]   <= '0;
        rd_ptr[k]   <= '0;
        count[k]    <= '0;
        wait_cnt[k] <= '0;
      end
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + PW'(1);
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + PW'(1);
        case ({push[k], pop[k]})
          2'b10:   count[k] <= count[k] + CW'(1);
          2'b01:   count[k] <= count[k] - CW'(1);
          default: count[k] <= count[k];
        endcase
        if (pop[k] || !nonempty[k])
          wait_cnt[k] <= '0;
        else if (wait_cnt[k] != WW'(STARVE_LIMIT))
          wait_cnt[k] <= wait_cnt[k] + WW'(1);
      end
      cdb_valid <= grant_any;
      if (grant_any) begin
        cdb_rob_idx <= head.rob;
        cdb_rd_addr <= head.rd;
        cdb_data    <= head.data;
        cdb_src     <= 2'(grant_idx);
        rr_ptr      <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: vector table for ordering/latency plus
// hand sequences for back-pressure, starvation, flush and async reset.
module tb_cdb_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [3:0]        req_valid;
  logic [3:0]        req_ready;
  logic [3:0][4:0]   req_rob_idx;
  logic [3:0][4:0]   req_rd_addr;
  logic [3:0][31:0]  req_data;
  logic              cdb_valid;
  logic [4:0]        cdb_rob_idx;
  logic [4:0]        cdb_rd_addr;
  logic [31:0]       cdb_data;
  logic [1:0]        cdb_src;

  int checks   = 0;
  int failures = 0;

  cdb_arbiter #(.NUM_REQ(4), .FIFO_DEPTH(2), .STARVE_LIMIT(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rob_idx(req_rob_idx),
    .req_rd_addr(req_rd_addr),
    .req_data   (req_data),
    .cdb_valid  (cdb_valid),
    .cdb_rob_idx(cdb_rob_idx),
    .cdb_rd_addr(cdb_rd_addr),
    .cdb_data   (cdb_data),
    .cdb_src    (cdb_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       flush;
    logic [3:0] push;
    logic       e_valid;
    int         e_src;
    int         e_tag;
  } vec_t;

  vec_t tbl [19];

  function automatic logic [41:0] pay(input int t, input int i);
    logic [4:0] r;
    logic [4:0] d;
    r = 5'((t * 4 + i) % 32);
    d = 5'((t * 3 + i * 7 + 1) % 32);
    return {r, d, 8'hC0, 8'(t), 8'(i), 8'h5A};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] mask, input int tag);
    logic [41:0] p;
    for (int i = 0; i < 4; i++) begin
      p = pay(tag, i);
      req_valid[i]   = mask[i];
      req_rob_idx[i] = p[41:37];
      req_rd_addr[i] = p[36:32];
      req_data[i]    = p[31:0];
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    drive(4'b0000, 0);
    tick();
    flush = 1'b0;
  endtask

  task automatic check_cdb(input string name, input int src, input int tag);
    check({name, "_valid"}, 64'(cdb_valid), 64'(1));
    check({name, "_src"}, 64'(cdb_src), 64'(src));
    check({name, "_payload"}, 64'({cdb_rob_idx, cdb_rd_addr, cdb_data}), 64'(pay(tag, src)));
  endtask

  task automatic count_idle(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (cdb_valid) seen++;
    end
    check(name, 64'(seen), 64'(0));
  endtask

  task automatic single_push(input string name);
    drive(4'b0000, 0);
    req_valid[0]   = 1'b1;
    req_rob_idx[0] = 5'd3;
    req_rd_addr[0] = 5'd5;
    req_data[0]    = 32'hDEADBEEF;
    tick();
    drive(4'b0000, 0);
    check({name, "_edge1_valid"}, 64'(cdb_valid), 64'(0));
    tick();
    check({name, "_valid"}, 64'(cdb_valid), 64'(1));
    check({name, "_src"}, 64'(cdb_src), 64'(0));
    check({name, "_payload"}, 64'({cdb_rob_idx, cdb_rd_addr, cdb_data}), {22'd0, 5'd3, 5'd5, 32'hDEADBEEF});
    tick();
    check({name, "_after_valid"}, 64'(cdb_valid), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [41:0] exp_pay;

    tbl[0]  = '{1'b0, 4'b0001, 1'b0, 0, -1};
    tbl[1]  = '{1'b0, 4'b0000, 1'b1, 0, 0};
    tbl[2]  = '{1'b0, 4'b0000, 1'b0, 0, 0};
    tbl[3]  = '{1'b1, 4'b0000, 1'b0, 0, 0};
    tbl[4]  = '{1'b0, 4'b1111, 1'b0, 0, 0};
    tbl[5]  = '{1'b0, 4'b0000, 1'b1, 0, 4};
    tbl[6]  = '{1'b0, 4'b0000, 1'b1, 1, 4};
    tbl[7]  = '{1'b0, 4'b0000, 1'b1, 2, 4};
    tbl[8]  = '{1'b0, 4'b0000, 1'b1, 3, 4};
    tbl[9]  = '{1'b0, 4'b0000, 1'b0, 3, 4};
    tbl[10] = '{1'b0, 4'b1010, 1'b0, 3, 4};
    tbl[11] = '{1'b0, 4'b0100, 1'b1, 1, 10};
    tbl[12] = '{1'b0, 4'b0000, 1'b1, 2, 11};
    tbl[13] = '{1'b0, 4'b0000, 1'b1, 3, 10};
    tbl[14] = '{1'b0, 4'b0000, 1'b0, 3, 10};
    tbl[15] = '{1'b0, 4'b0001, 1'b0, 3, 10};
    tbl[16] = '{1'b0, 4'b0001, 1'b1, 0, 15};
    tbl[17] = '{1'b0, 4'b0000, 1'b1, 0, 16};
    tbl[18] = '{1'b0, 4'b0000, 1'b0, 0, 16};

    rst   = 1'b0;
    flush = 1'b0;
    drive(4'b0000, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 64'(cdb_valid), 64'(0));
    check("reset_payload", 64'({cdb_rob_idx, cdb_rd_addr, cdb_data}), 64'(0));
    check("reset_src", 64'(cdb_src), 64'(0));
    check("reset_ready", 64'(req_ready), 64'(4'hF));
    rst = 1'b1;

    for (int r = 0; r < 19; r++) begin
      flush = tbl[r].flush;
      drive(tbl[r].push, r);
      tick();
      flush = 1'b0;
      check($sformatf("vec%0d_valid", r), 64'(cdb_valid), 64'(tbl[r].e_valid));
      check($sformatf("vec%0d_ready", r), 64'(req_ready), 64'(4'hF));
      if (tbl[r].e_valid)
        check($sformatf("vec%0d_src", r), 64'(cdb_src), 64'(tbl[r].e_src));
      exp_pay = (tbl[r].e_tag < 0) ? '0 : pay(tbl[r].e_tag, tbl[r].e_src);
      check($sformatf("vec%0d_payload", r), 64'({cdb_rob_idx, cdb_rd_addr, cdb_data}), 64'(exp_pay));
    end
    drive(4'b0000, 0);

    do_flush();
    single_push("single");

    // Back-pressure: mul fills while alu wins, third offer waits for a pop.
    do_flush();
    drive(4'b0011, 101);
    tick();
    check("bp_e1_valid", 64'(cdb_valid), 64'(0));
    check("bp_e1_ready1", 64'(req_ready[1]), 64'(1));
    drive(4'b0011, 102);
    tick();
    check_cdb("bp_e2", 0, 101);
    check("bp_e2_ready1", 64'(req_ready[1]), 64'(0));
    drive(4'b0010, 103);
    tick();
    check_cdb("bp_e3", 1, 101);
    check("bp_e3_ready1", 64'(req_ready[1]), 64'(1));
    tick();
    check_cdb("bp_e4", 0, 102);
    check("bp_e4_ready1", 64'(req_ready[1]), 64'(0));
    drive(4'b0000, 0);
    tick();
    check_cdb("bp_e5", 1, 102);
    tick();
    check_cdb("bp_e6", 1, 103);
    tick();
    check("bp_e7_valid", 64'(cdb_valid), 64'(0));

    // Starvation: requester 1 saturates while rr_ptr points at requester 0.
    do_flush();
    drive(4'b0010, 201);
    tick();
    check("st_e1_valid", 64'(cdb_valid), 64'(0));
    drive(4'b1110, 202);
    tick();
    check_cdb("st_e2", 1, 201);
    drive(4'b0001, 203);
    tick();
    check_cdb("st_e3", 2, 202);
    drive(4'b0000, 0);
    tick();
    check_cdb("st_e4", 3, 202);
    tick();
    check_cdb("st_e5", 1, 202);
    tick();
    check_cdb("st_e6", 0, 203);
    tick();
    check("st_e7_valid", 64'(cdb_valid), 64'(0));

    // Flush with three buffered entries and a same-cycle push.
    do_flush();
    drive(4'b0111, 301);
    tick();
    check("fl_e1_valid", 64'(cdb_valid), 64'(0));
    flush = 1'b1;
    drive(4'b1001, 302);
    tick();
    flush = 1'b0;
    drive(4'b0000, 0);
    check("fl_valid", 64'(cdb_valid), 64'(0));
    check("fl_ready", 64'(req_ready), 64'(4'hF));
    count_idle("fl_no_stale", 6);

    // Asynchronous reset between edges with data buffered.
    do_flush();
    drive(4'b0011, 401);
    tick();
    drive(4'b0000, 0);
    tick();
    check_cdb("ar_pre", 0, 401);
    #3;
    rst = 1'b0;
    #1;
    check("ar_valid", 64'(cdb_valid), 64'(0));
    check("ar_payload", 64'({cdb_rob_idx, cdb_rd_addr, cdb_data}), 64'(0));
    check("ar_src", 64'(cdb_src), 64'(0));
    check("ar_ready", 64'(req_ready), 64'(4'hF));
    tick();
    rst = 1'b1;
    count_idle("ar_no_stale", 6);
    single_push("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
